// File: rtl/mmc1_loader.sv
// Programs an MMC1-class mapper's serial load register from a parallel command:
// optional shift-register reset write, then five one-bit writes LSB first, bus held throughout.
module mmc1_loader #(
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_reg,
  input  logic [4:0]  cmd_val,
  input  logic        cmd_rst,
  output logic        busreq,
  input  logic        busgnt,
  output logic [15:0] memaddr,
  output logic [7:0]  memwdata,
  output logic        memwr,
  output logic        prgreq,
  input  logic        prgack,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Index 5 marks the shift-register reset write that precedes data write 0.
  localparam logic [2:0] IDX_R  = 3'd5;
  localparam logic [2:0] IDX_LAST = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_idx;
  logic [1:0]  r_reg;
  logic [4:0]  r_val;
  logic [7:0]  r_tmo;
  logic [7:0]  r_gap;
  logic        r_cmd_ready;
  logic        r_busreq;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_prgreq;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [2:0]  w_nidx;
  logic [2:0]  w_sel;
  logic [4:0]  w_shift;
  logic [15:0] w_addr;
  logic [7:0]  w_data;

  // Leaving GAP launches the next write, so its address/data come from the advanced index.
  assign w_nidx  = (r_idx == IDX_R) ? 3'd0 : r_idx + 3'd1;
  assign w_sel   = (r_state == S_GAP) ? w_nidx : r_idx;
  assign w_shift = r_val >> w_sel;
  assign w_addr  = (w_sel == IDX_R) ? 16'h8000 : {1'b1, r_reg, 13'h0};
  assign w_data  = (w_sel == IDX_R) ? 8'h80 : {7'b0, w_shift[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_reg       <= 2'd0;
      r_val       <= 5'd0;
      r_tmo       <= 8'd0;
      r_gap       <= 8'd0;
      r_cmd_ready <= 1'b1;
      r_busreq    <= 1'b0;
      r_addr      <= 16'h0;
      r_wdata     <= 8'h0;
      r_prgreq    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (cmd_valid && r_cmd_ready) begin
          r_reg       <= cmd_reg;
          r_val       <= cmd_val;
          r_idx       <= cmd_rst ? IDX_R : 3'd0;
          r_busreq    <= 1'b1;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= S_ARB;
        end
        S_ARB: if (busgnt) begin
          r_addr   <= w_addr;
          r_wdata  <= w_data;
          r_prgreq <= 1'b1;
          r_tmo    <= 8'd0;
          r_state  <= S_WR;
        end
        S_WR: begin
          if (prgack) begin
            r_prgreq <= 1'b0;
            r_gap    <= 8'd0;
            r_state  <= S_GAP;
          end else if (r_tmo == 8'(TIMEOUT - 1)) begin
            r_err       <= 1'b1;
            r_prgreq    <= 1'b0;
            r_busreq    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
          end
        end
        S_GAP: begin
          if (r_gap == 8'(GAP - 1)) begin
            if (r_idx == IDX_LAST) begin
              r_done   <= 1'b1;
              r_busreq <= 1'b0;
              r_state  <= S_FIN;
            end else begin
              r_idx <= w_nidx;
              if (busgnt) begin
                r_addr   <= w_addr;
                r_wdata  <= w_data;
                r_prgreq <= 1'b1;
                r_tmo    <= 8'd0;
                r_state  <= S_WR;
              end else begin
                r_state <= S_ARB;
              end
            end
          end else begin
            r_gap <= r_gap + 8'd1;
          end
        end
        S_FIN: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busreq    = r_busreq;
  assign memaddr   = r_addr;
  assign memwdata  = r_wdata;
  assign memwr     = r_prgreq;
  assign prgreq    = r_prgreq;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
endmodule

// File: tb/tb_mmc1_loader.sv
// Directed bench for mmc1_loader with an edge-triggered MMC1 mapper model answering prgack.
module tb_mmc1_loader;
  logic        clk, reset, cmd_valid, cmd_rst, busgnt, prgack;
  logic [1:0]  cmd_reg;
  logic [4:0]  cmd_val;
  logic        cmd_ready, busreq, memwr, prgreq, busy, done, err;
  logic [15:0] memaddr;
  logic [7:0]  memwdata;

  mmc1_loader #(.GAP(1), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reg(cmd_reg), .cmd_val(cmd_val), .cmd_rst(cmd_rst),
    .busreq(busreq), .busgnt(busgnt), .memaddr(memaddr), .memwdata(memwdata),
    .memwr(memwr), .prgreq(prgreq), .prgack(prgack), .busy(busy),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mapper model: 0 ack always high, 1 ack after 4 cycles of prgreq, 2 never ack.
  int          mode = 0;
  int          hcnt = 0;
  int          nw = 0, prg_hi = 0, unstable = 0, wr_mis = 0;
  logic        prev = 1'b0;
  logic [15:0] log_a[64];
  logic [7:0]  log_d[64];
  logic [15:0] cap_a;
  logic [7:0]  cap_d;
  logic [4:0]  sh = 5'd0;
  int          sc = 0;
  logic [4:0]  mreg[4];

  assign prgack = (mode == 0) ? 1'b1 : (mode == 1) ? (prgreq && hcnt >= 4) : 1'b0;

  initial begin
    for (int k = 0; k < 4; k++) mreg[k] = 5'd0;
    forever begin
      @(negedge clk);
      if (prgreq && !prev) begin
        if (nw < 64) begin
          log_a[nw] = memaddr;
          log_d[nw] = memwdata;
        end
        nw++;
        cap_a = memaddr;
        cap_d = memwdata;
        if (memwdata[7]) begin
          sh = 5'd0;
          sc = 0;
        end else begin
          sh = {memwdata[0], sh[4:1]};
          sc++;
          if (sc == 5) begin
            mreg[memaddr[14:13]] = sh;
            sh = 5'd0;
            sc = 0;
          end
        end
      end else if (prgreq && prev) begin
        if (memaddr !== cap_a || memwdata !== cap_d) unstable++;
      end
      if (memwr !== prgreq) wr_mis++;
      if (prgreq) begin
        prg_hi++;
        hcnt++;
      end else begin
        hcnt = 0;
      end
      prev = prgreq;
    end
  end

  task automatic issue(input logic [1:0] r, input logic [4:0] v, input logic rs);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_reg = r; cmd_val = v; cmd_rst = rs;
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_reg = 2'd0; cmd_val = 5'd0; cmd_rst = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the accept edge.
  task automatic wait_end(input int maxc, output int cyc, output logic gd, output logic ge);
    cyc = 0; gd = 1'b0; ge = 1'b0;
    while (cyc < maxc && !gd && !ge) begin
      @(negedge clk);
      cyc++;
      gd = done;
      ge = err;
    end
  endtask

  int          cyc, base, hbase, ubase, wait_n;
  logic        gd, ge;
  int          exp1[5] = '{0, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_reg = 2'd0; cmd_val = 5'd0; cmd_rst = 1'b0; busgnt = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busreq", busreq, 0);
    chk("rst_memaddr", memaddr, 0);
    chk("rst_memwdata", memwdata, 0);
    chk("rst_prgreq", prgreq, 0);
    chk("rst_memwr", memwr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // 1: ctrl <- 0E, no reset write, immediate ack
    mode = 0; base = nw;
    issue(2'd0, 5'h0E, 1'b0);
    wait_end(40, cyc, gd, ge);
    chk("t1_done", gd, 1);
    chk("t1_latency", cyc, 12);
    chk("t1_busreq_fin", busreq, 0);
    chk("t1_nwrites", nw - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t1_addr", log_a[base+i], 16'h8000);
      chk("t1_data", log_d[base+i], exp1[i]);
    end
    chk("t1_mapper_ctrl", mreg[0], 5'h0E);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_after", cmd_ready, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_addr_hold", memaddr, 16'h8000);
    chk("t1_data_hold", memwdata, 8'h00);

    // 2: reset write then prg <- 1F
    base = nw;
    issue(2'd3, 5'h1F, 1'b1);
    wait_end(40, cyc, gd, ge);
    chk("t2_done", gd, 1);
    chk("t2_latency", cyc, 14);
    chk("t2_nwrites", nw - base, 6);
    chk("t2_rst_addr", log_a[base], 16'h8000);
    chk("t2_rst_data", log_d[base], 8'h80);
    for (int i = 1; i < 6; i++) begin
      chk("t2_addr", log_a[base+i], 16'hE000);
      chk("t2_data", log_d[base+i], 8'h01);
    end
    chk("t2_mapper_prg", mreg[3], 5'h1F);

    // 3: delayed ack, chr0 <- 15
    mode = 1; base = nw; hbase = prg_hi; ubase = unstable;
    issue(2'd1, 5'h15, 1'b0);
    wait_end(100, cyc, gd, ge);
    chk("t3_done", gd, 1);
    chk("t3_latency", cyc, 1 + 5 * (4 + 1) + 1);
    chk("t3_edges", nw - base, 5);
    chk("t3_req_cycles", prg_hi - hbase, 20);
    chk("t3_stable", unstable - ubase, 0);
    chk("t3_mapper_chr0", mreg[1], 5'h15);

    // 4: never acked -> timeout abort
    mode = 2; base = nw; hbase = prg_hi;
    issue(2'd2, 5'h03, 1'b0);
    wait_end(400, cyc, gd, ge);
    chk("t4_err", ge, 1);
    chk("t4_no_done", gd, 0);
    chk("t4_latency", cyc, 257);
    chk("t4_wr_cycles", prg_hi - hbase, 255);
    chk("t4_busreq", busreq, 0);
    chk("t4_prgreq", prgreq, 0);
    @(negedge clk);
    chk("t4_err_pulse", err, 0);
    chk("t4_ready_after", cmd_ready, 1);
    chk("t4_done_after", done, 0);

    // 5: grant withdrawn in the gap after the second data write
    mode = 0; base = nw;
    issue(2'd2, 5'h0B, 1'b1);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(nw - base == 3 && !prgreq) && wait_n < 50);
    chk("t5_reached_gap", wait_n < 50, 1);
    busgnt = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_arb_busreq", busreq, 1);
    chk("t5_arb_prgreq", prgreq, 0);
    chk("t5_arb_busy", busy, 1);
    chk("t5_arb_nwrites", nw - base, 3);
    busgnt = 1'b1;
    wait_end(40, cyc, gd, ge);
    chk("t5_done", gd, 1);
    chk("t5_nwrites", nw - base, 6);
    chk("t5_resume_addr", log_a[base+3], 16'hC000);
    chk("t5_resume_data", log_d[base+3], 8'h00);
    chk("t5_mapper_chr1", mreg[2], 5'h0B);

    // 6: reset during a write, then a fresh command
    mode = 2;
    issue(2'd0, 5'h1F, 1'b0);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!prgreq && wait_n < 10);
    chk("t6_in_wr", prgreq, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_prgreq", prgreq, 0);
    chk("t6_busreq", busreq, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_memwr", memwr, 0);
    reset = 1'b0;
    mode = 0; base = nw;
    issue(2'd0, 5'h13, 1'b1);
    wait_end(40, cyc, gd, ge);
    chk("t6_done", gd, 1);
    chk("t6_err", ge, 0);
    chk("t6_latency", cyc, 14);
    chk("t6_mapper_ctrl", mreg[0], 5'h13);

    chk("memwr_tracks_prgreq", wr_mis, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
